dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-channel memory responder: each channel runs its own IDLE/BUSY/RESPOND/RELEASE
// handshake FSM against a shared, resettable word store with a backdoor preload port.
module dmem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  output logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_ready,
  input  logic                                     init_valid,
  input  logic [ADDR_BITS-1:0]                     init_address,
  input  logic [DATA_BITS-1:0]                     init_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESPOND,
    S_RELEASE
  } state_t;

  logic [DATA_BITS-1:0]                   mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0]                wr_commit;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data;

  // Later assignments win: preload first, then channels in ascending index order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      if (init_valid) begin
        mem_q[init_address] <= init_data;
      end
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_commit[i]) begin
          mem_q[wr_addr[i]] <= wr_data[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 rready_q, rready_d;
    logic                 wready_q, wready_d;
    logic                 op_valid;

    // RELEASE waits only on the valid of the operation that was actually accepted.
    assign op_valid = op_wr_q ? mem_write_valid[gi] : mem_read_valid[gi];

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_wr_d  = op_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rready_d = 1'b0;
      wready_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_read_valid[gi]) begin
            op_wr_d = 1'b0;
            addr_d  = mem_read_address[gi];
            cnt_d   = CNT_W'(LATENCY);
            state_d = S_BUSY;
          end else if (mem_write_valid[gi]) begin
            op_wr_d = 1'b1;
            addr_d  = mem_write_address[gi];
            wdata_d = mem_write_data[gi];
            cnt_d   = CNT_W'(LATENCY);
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_d = S_RESPOND;
            if (op_wr_q) begin
              wready_d = 1'b1;
            end else begin
              rready_d = 1'b1;
              rdata_d  = mem_q[addr_q];
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_RESPOND: begin
          state_d = S_RELEASE;
        end
        S_RELEASE: begin
          if (!op_valid) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        op_wr_q  <= 1'b0;
        addr_q   <= '0;
        wdata_q  <= '0;
        rdata_q  <= '0;
        rready_q <= 1'b0;
        wready_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        op_wr_q  <= op_wr_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata_q  <= rdata_d;
        rready_q <= rready_d;
        wready_q <= wready_d;
      end
    end

    // The write commits on the same edge that raises the write acknowledge.
    assign wr_commit[gi]       = (state_q == S_BUSY) && (cnt_q == '0) && op_wr_q;
    assign wr_addr[gi]         = addr_q;
    assign wr_data[gi]         = wdata_q;
    assign mem_read_ready[gi]  = rready_q;
    assign mem_read_data[gi]   = rdata_q;
    assign mem_write_ready[gi] = wready_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, hand-written corner sequences,
// and randomized concurrent rounds checked against a round-level memory model.
module tb_dmem_responder;
  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NC-1:0]          mem_read_valid;
  logic [NC-1:0][AB-1:0]  mem_read_address;
  logic [NC-1:0]          mem_read_ready;
  logic [NC-1:0][DB-1:0]  mem_read_data;
  logic [NC-1:0]          mem_write_valid;
  logic [NC-1:0][AB-1:0]  mem_write_address;
  logic [NC-1:0][DB-1:0]  mem_write_data;
  logic [NC-1:0]          mem_write_ready;
  logic                   init_valid;
  logic [AB-1:0]          init_address;
  logic [DB-1:0]          init_data;

  dmem_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .init_valid(init_valid), .init_address(init_address), .init_data(init_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [9];
  logic [7:0] ref_mem [256];
  int         r_op [NC];
  logic [7:0] r_ad [NC];
  logic [7:0] r_wd [NC];
  logic [7:0] r_ex [NC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Counts negedges from k0 until the selected ready is seen; bounded to 20 cycles.
  task automatic wait_pulse(input int ch, input bit wr, input int k0, output int k);
    bit seen = 1'b0;
    k = k0;
    while (!seen && k < k0 + 20) begin
      @(negedge clk);
      if (wr ? mem_write_ready[ch] : mem_read_ready[ch]) seen = 1'b1;
      else k++;
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    init_address = addr;
    init_data    = data;
    init_valid   = 1'b1;
    @(posedge clk); #1;
    init_valid   = 1'b0;
  endtask

  // One full handshake; entered and left just after a rising edge, with valid
  // low for exactly one cycle after the ready pulse.
  task automatic chan_op(input int ch, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp, input string tag);
    int k;
    if (wr) begin
      mem_write_address[ch] = addr;
      mem_write_data[ch]    = wdata;
      mem_write_valid[ch]   = 1'b1;
    end else begin
      mem_read_address[ch]  = addr;
      mem_read_valid[ch]    = 1'b1;
    end
    wait_pulse(ch, wr, 0, k);
    check({tag, " latency"}, k, LAT + 2);
    if (!wr) check({tag, " rdata"}, mem_read_data[ch], exp);
    $display("txn %s ch%0d %s addr=0x%02h data=0x%02h lat=%0d", tag, ch, wr ? "WR" : "RD",
             addr, wr ? wdata : mem_read_data[ch], k);
    @(posedge clk); #1;
    if (wr) mem_write_valid[ch] = 1'b0;
    else    mem_read_valid[ch]  = 1'b0;
    @(negedge clk);
    check({tag, " single-cycle ready"}, wr ? mem_write_ready[ch] : mem_read_ready[ch], 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    mem_read_valid = '0; mem_read_address = '0;
    mem_write_valid = '0; mem_write_address = '0; mem_write_data = '0;
    init_valid = 1'b0; init_address = '0; init_data = '0;
    reset = 1'b1;

    tbl[0] = '{0, 1'b1, 8'h01, 8'h5E, 8'h00};
    tbl[1] = '{1, 1'b0, 8'h01, 8'h00, 8'h5E};
    tbl[2] = '{2, 1'b1, 8'h02, 8'hA7, 8'h00};
    tbl[3] = '{3, 1'b0, 8'h02, 8'h00, 8'hA7};
    tbl[4] = '{2, 1'b1, 8'h01, 8'h00, 8'h00};
    tbl[5] = '{0, 1'b0, 8'h01, 8'h00, 8'h00};
    tbl[6] = '{3, 1'b1, 8'hFF, 8'hFF, 8'h00};
    tbl[7] = '{1, 1'b0, 8'hFF, 8'h00, 8'hFF};
    tbl[8] = '{0, 1'b0, 8'h00, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("reset rready%0d", c), mem_read_ready[c], 0);
      check($sformatf("reset wready%0d", c), mem_write_ready[c], 0);
      check($sformatf("reset rdata%0d", c), mem_read_data[c], 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      chan_op(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));

    // Preloaded word read back, then held on the output while idle.
    preload(8'h10, 8'hAB);
    chan_op(0, 1'b0, 8'h10, 8'h00, 8'hAB, "preload read");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rdata hold", mem_read_data[0], 8'hAB);
    @(posedge clk); #1;

    // Back-to-back reads with a one-cycle valid gap.
    preload(8'h20, 8'hC3);
    preload(8'h21, 8'h3C);
    chan_op(1, 1'b0, 8'h20, 8'h00, 8'hC3, "b2b first");
    chan_op(1, 1'b0, 8'h21, 8'h00, 8'h3C, "b2b second");

    // Same-edge write and read of one address: the read sees the old word.
    fork
      chan_op(1, 1'b1, 8'h30, 8'h5A, 8'h00, "rw-race write");
      chan_op(2, 1'b0, 8'h30, 8'h00, 8'h00, "rw-race read");
    join
    chan_op(0, 1'b0, 8'h30, 8'h00, 8'h5A, "rw-race readback");

    // Same-edge writes to one address: the highest channel wins.
    fork
      chan_op(0, 1'b1, 8'h40, 8'h11, 8'h00, "ww ch0");
      chan_op(3, 1'b1, 8'h40, 8'h33, 8'h00, "ww ch3");
    join
    chan_op(2, 1'b0, 8'h40, 8'h00, 8'h33, "ww readback");

    // Read and write valid together: read first, write only after the read releases.
    preload(8'h50, 8'h77);
    mem_read_address[3] = 8'h50;  mem_read_valid[3] = 1'b1;
    mem_write_address[3] = 8'h50; mem_write_data[3] = 8'h99; mem_write_valid[3] = 1'b1;
    wait_pulse(3, 1'b0, 0, k);
    check("dual read latency", k, LAT + 2);
    check("dual read data", mem_read_data[3], 8'h77);
    check("dual no early wready", mem_write_ready[3], 0);
    @(posedge clk); #1;
    mem_read_valid[3] = 1'b0;
    // RELEASE in this cycle, IDLE accepts the write one cycle later.
    wait_pulse(3, 1'b1, 0, k);
    check("dual write latency", k, LAT + 3);
    @(posedge clk); #1;
    mem_write_valid[3] = 1'b0;
    @(negedge clk);
    check("dual wready single", mem_write_ready[3], 0);
    @(posedge clk); #1;
    chan_op(3, 1'b0, 8'h50, 8'h00, 8'h99, "dual readback");

    // Valid dropped during BUSY: the write still commits and acknowledges.
    mem_write_address[0] = 8'h70; mem_write_data[0] = 8'h4D; mem_write_valid[0] = 1'b1;
    @(posedge clk); #1;
    mem_write_valid[0] = 1'b0;
    wait_pulse(0, 1'b1, 1, k);
    check("abort-free wready cycle", k, LAT + 2);
    @(negedge clk);
    check("abort-free wready single", mem_write_ready[0], 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chan_op(0, 1'b0, 8'h70, 8'h00, 8'h4D, "abort-free readback");

    // Reset during BUSY with valid held: no pulse, storage cleared, preload ignored.
    mem_read_address[0] = 8'h10; mem_read_valid[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    init_address = 8'h60; init_data = 8'hEE; init_valid = 1'b1;
    @(negedge clk);
    check("reset-busy no rready", mem_read_ready[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    init_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NC; c++)
      check($sformatf("post-reset rdata%0d", c), mem_read_data[c], 0);
    check("post-reset no rready", mem_read_ready[0], 0);
    wait_pulse(0, 1'b0, 1, k);
    check("post-reset latency", k, LAT + 2);
    check("post-reset cleared 0x10", mem_read_data[0], 8'h00);
    @(posedge clk); #1;
    mem_read_valid[0] = 1'b0;
    @(posedge clk); #1;
    chan_op(1, 1'b0, 8'h40, 8'h00, 8'h00, "cleared 0x40");
    chan_op(2, 1'b0, 8'h60, 8'h00, 8'h00, "init ignored 0x60");

    // Randomized concurrent rounds; storage is all zero after the reset above.
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] pa, pd;
        pa = 8'(8'h80 + $urandom_range(0, 7));
        pd = 8'($urandom);
        preload(pa, pd);
        ref_mem[pa] = pd;
      end
      for (int c = 0; c < NC; c++) begin
        r_op[c] = $urandom_range(0, 2);
        r_ad[c] = 8'(8'h80 + $urandom_range(0, 7));
        r_wd[c] = 8'($urandom);
        r_ex[c] = ref_mem[r_ad[c]];
      end
      for (int c = 0; c < NC; c++)
        if (r_op[c] == 2) ref_mem[r_ad[c]] = r_wd[c];
      for (int c = 0; c < NC; c++) begin
        if (r_op[c] != 0) begin
          automatic int cc = c;
          fork
            chan_op(cc, r_op[cc] == 2, r_ad[cc], r_wd[cc], r_ex[cc], $sformatf("rnd%0d", r));
          join_none
        end
      end
      wait fork;
    end
    for (int a = 8'h80; a < 8'h88; a++)
      chan_op(a % NC, 1'b0, 8'(a), 8'h00, ref_mem[a], "final sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
